// File: rtl/sd_cmd_rsp_rcvr_pkg.sv
// Shared definitions for the SD CMD-line response receiver and the CRC7 engine.
// One-hot FSM encodings, response lengths and the CRC7 step function.
package sd_cmd_rsp_rcvr_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_WAIT  = 5'b00010,
    S_SHIFT = 5'b00100,
    S_CHECK = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  localparam int RSP_SHORT_LEN = 48;
  localparam int RSP_LONG_LEN  = 136;
  localparam int NCR_MAX_DEF   = 64;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_rsp_rcvr_if.sv
// Command-response bus between the SD host controller and the response receiver.
// master drives the line/arming side, slave is the receiver.
interface sd_cmd_rsp_rcvr_if;
  logic         sdc_clk;
  logic         sd_clk_stable;
  logic         rsp_start_strb;
  logic         rsp_long;
  logic         chk_crc;
  logic         sd_cmd_in;
  logic         rsp_busy;
  logic [5:0]   rsp_index;
  logic [127:0] rsp_arg;
  logic         rsp_done_strb;
  logic         rsp_crc_err;
  logic         rsp_end_err;
  logic         rsp_timeout;

  modport master (
    output sdc_clk, sd_clk_stable, rsp_start_strb, rsp_long, chk_crc, sd_cmd_in,
    input  rsp_busy, rsp_index, rsp_arg, rsp_done_strb, rsp_crc_err, rsp_end_err, rsp_timeout
  );

  modport slave (
    input  sdc_clk, sd_clk_stable, rsp_start_strb, rsp_long, chk_crc, sd_cmd_in,
    output rsp_busy, rsp_index, rsp_arg, rsp_done_strb, rsp_crc_err, rsp_end_err, rsp_timeout
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one bit per enb cycle; result valid the cycle after the last bit.
// No backpressure: the caller gates enb.
module sd_crc7
  import sd_cmd_rsp_rcvr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       enb,
  input  logic       bit_in,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clr) crc <= 7'h00;
    else if (enb)     crc <= crc7_step(crc, bit_in);
  end

endmodule

// File: rtl/sd_cmd_rsp_rcvr.sv
// Receives 48/136-bit SD responses on the CMD line; rsp_done_strb fires 2 clk after the end-bit edge.
// No backpressure: rsp_start_strb is ignored while busy, results hold until the next arm.
module sd_cmd_rsp_rcvr
  import sd_cmd_rsp_rcvr_pkg::*;
#(
  parameter int NCR_MAX     = NCR_MAX_DEF,
  parameter bit CHK_CRC_DEF = 1'b1
) (
  input logic             clk,
  input logic             reset,
  sd_cmd_rsp_rcvr_if.slave bus
);

  localparam int ECW = $clog2(NCR_MAX + 1);
  localparam logic [ECW-1:0] NCR_LAST = ECW'(NCR_MAX - 1);
  localparam logic [7:0] LAST_SHORT = 8'(RSP_SHORT_LEN - 1);
  localparam logic [7:0] LAST_LONG  = 8'(RSP_LONG_LEN - 1);

  state_t         state, nxt;
  logic           sdc_q, edge_strb;
  logic [ECW-1:0] ecnt;
  logic [7:0]     bcnt, last_bit;
  logic [127:0]   sr;
  logic           long_q, chk_q;
  logic           crc_err_q, end_err_q, timeout_q;
  logic [5:0]     index_q;
  logic [127:0]   arg_q;
  logic           crc_clr, crc_enb, crc_win, sample;
  logic [6:0]     crc;

  assign edge_strb = ~sdc_q & bus.sdc_clk;
  assign last_bit  = long_q ? LAST_LONG : LAST_SHORT;
  assign sample    = edge_strb && bus.sd_clk_stable &&
                     ((state == S_SHIFT) || (state == S_WAIT && !bus.sd_cmd_in));
  // CRC covers bits 47..8 (short) or 127..8 (long); bcnt is bits already received.
  assign crc_win   = long_q ? (bcnt >= 8'd8 && bcnt <= 8'd127) : (bcnt <= 8'd39);
  assign crc_enb   = sample && crc_win;
  assign crc_clr   = (state == S_IDLE) && bus.rsp_start_strb;

  sd_crc7 u_crc7 (
    .clk    (clk),
    .reset  (reset),
    .clr    (crc_clr),
    .enb    (crc_enb),
    .bit_in (bus.sd_cmd_in),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.rsp_start_strb) nxt = bus.sd_clk_stable ? S_WAIT : S_DONE;
      S_WAIT: begin
        if (!bus.sd_clk_stable) nxt = S_DONE;
        else if (edge_strb) begin
          if (!bus.sd_cmd_in)        nxt = S_SHIFT;
          else if (ecnt == NCR_LAST) nxt = S_DONE;
        end
      end
      S_SHIFT: begin
        if (!bus.sd_clk_stable)                nxt = S_DONE;
        else if (edge_strb && bcnt == last_bit) nxt = S_CHECK;
      end
      S_CHECK: nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rsp_busy      = 1'b0;
    bus.rsp_done_strb = 1'b0;
    case (state)
      S_WAIT, S_SHIFT, S_CHECK: bus.rsp_busy = 1'b1;
      S_DONE:                   bus.rsp_done_strb = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sdc_q     <= 1'b0;
      ecnt      <= '0;
      bcnt      <= 8'd0;
      sr        <= '0;
      long_q    <= 1'b0;
      chk_q     <= CHK_CRC_DEF;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      timeout_q <= 1'b0;
      index_q   <= 6'd0;
      arg_q     <= '0;
    end else begin
      sdc_q <= bus.sdc_clk;
      case (state)
        S_IDLE: if (bus.rsp_start_strb) begin
          long_q    <= bus.rsp_long;
          chk_q     <= bus.chk_crc;
          ecnt      <= '0;
          bcnt      <= 8'd0;
          crc_err_q <= 1'b0;
          end_err_q <= 1'b0;
          timeout_q <= ~bus.sd_clk_stable;
        end
        S_WAIT: begin
          if (!bus.sd_clk_stable) timeout_q <= 1'b1;
          else if (edge_strb) begin
            if (!bus.sd_cmd_in) begin
              sr   <= {sr[126:0], bus.sd_cmd_in};
              bcnt <= 8'd1;
            end else begin
              ecnt <= ecnt + 1'b1;
              if (ecnt == NCR_LAST) timeout_q <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (!bus.sd_clk_stable) timeout_q <= 1'b1;
          else if (edge_strb) begin
            sr   <= {sr[126:0], bus.sd_cmd_in};
            bcnt <= bcnt + 8'd1;
          end
        end
        S_CHECK: begin
          end_err_q <= ~sr[0];
          crc_err_q <= chk_q && (crc != sr[7:1]);
          if (long_q) begin
            index_q <= 6'd0;
            arg_q   <= sr;
          end else begin
            index_q <= sr[45:40];
            arg_q   <= {96'd0, sr[39:8]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_index   = index_q;
  assign bus.rsp_arg     = arg_q;
  assign bus.rsp_crc_err = crc_err_q;
  assign bus.rsp_end_err = end_err_q;
  assign bus.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_sd_cmd_rsp_rcvr.sv
// Randomized bench for sd_cmd_rsp_rcvr with a reference model built from the response format.
module tb_sd_cmd_rsp_rcvr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_cmd_rsp_rcvr_if bus ();

  sd_cmd_rsp_rcvr #(.NCR_MAX(64), .CHK_CRC_DEF(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Done-strobe monitor, sampled mid-cycle.
  int           done_cnt = 0, done_cyc = -1;
  logic [127:0] cap_arg;
  logic [5:0]   cap_idx;
  logic         cap_crc, cap_end, cap_to;
  always @(negedge clk) begin
    if (bus.rsp_done_strb) begin
      done_cnt++;
      done_cyc = cyc;
      cap_arg  = bus.rsp_arg;
      cap_idx  = bus.rsp_index;
      cap_crc  = bus.rsp_crc_err;
      cap_end  = bus.rsp_end_err;
      cap_to   = bus.rsp_timeout;
    end
  end

  // CRC7 as polynomial long division of msg(x)*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [135:0] m, input int n);
    logic [142:0] d;
    d = {m, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
    return d[6:0];
  endfunction

  function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg);
    logic [135:0] v;
    v = '0;
    v[47:8] = {2'b00, idx, arg};
    v[7:1]  = crc7_div({96'd0, v[47:8]}, 40);
    v[0]    = 1'b1;
    return v;
  endfunction

  function automatic logic [135:0] mk_long(input logic [119:0] body);
    logic [135:0] v;
    v = '0;
    v[135:128] = 8'h3F;
    v[127:8]   = body;
    v[7:1]     = crc7_div({16'd0, body}, 120);
    v[0]       = 1'b1;
    return v;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sd_bit(input logic b, output int ecyc);
    tick();
    bus.sdc_clk   = 1'b0;
    bus.sd_cmd_in = b;
    tick();
    bus.sdc_clk = 1'b1;
    ecyc = cyc;
    tick();
  endtask

  task automatic send(input logic [135:0] v, input int n, output int ecyc);
    for (int i = n - 1; i >= 0; i--) sd_bit(v[i], ecyc);
  endtask

  task automatic arm(input logic lng, input logic chk);
    bus.rsp_start_strb = 1'b1;
    bus.rsp_long       = lng;
    bus.chk_crc        = chk;
    tick();
    bus.rsp_start_strb = 1'b0;
  endtask

  task automatic run_rsp(input string tag, input logic [135:0] v, input logic lng,
                         input logic chk, input int idle);
    int d0, ec, n;
    logic [127:0] e_arg;
    logic [5:0]   e_idx;
    logic         e_crc;
    n     = lng ? 136 : 48;
    e_arg = lng ? v[127:0] : {96'd0, v[39:8]};
    e_idx = lng ? 6'd0 : v[45:40];
    e_crc = chk && (v[7:1] != (lng ? crc7_div({16'd0, v[127:8]}, 120)
                                   : crc7_div({96'd0, v[47:8]}, 40)));
    d0 = done_cnt;
    arm(lng, chk);
    for (int i = 0; i < idle; i++) sd_bit(1'b1, ec);
    send(v, n, ec);
    tick(4);
    check_val({tag, "_cnt"}, 128'(done_cnt - d0), 128'd1);
    check_val({tag, "_lat"}, 128'(done_cyc), 128'(ec + 2));
    check_val({tag, "_arg"}, cap_arg, e_arg);
    check_val({tag, "_idx"}, 128'(cap_idx), 128'(e_idx));
    check_val({tag, "_crc"}, 128'(cap_crc), 128'(e_crc));
    check_val({tag, "_end"}, 128'(cap_end), 128'(!v[0]));
    check_val({tag, "_to"},  128'(cap_to), 128'd0);
  endtask

  initial begin
    logic [135:0] v, va;
    int d0, ec, dc;
    reset              = 1'b1;
    bus.sdc_clk        = 1'b0;
    bus.sd_clk_stable  = 1'b1;
    bus.rsp_start_strb = 1'b0;
    bus.rsp_long       = 1'b0;
    bus.chk_crc        = 1'b1;
    bus.sd_cmd_in      = 1'b1;
    tick(3);
    check_val("rst_busy", 128'(bus.rsp_busy), 128'd0);
    check_val("rst_done", 128'(bus.rsp_done_strb), 128'd0);
    check_val("rst_flags", 128'({bus.rsp_crc_err, bus.rsp_end_err, bus.rsp_timeout}), 128'd0);
    check_val("rst_idx", 128'(bus.rsp_index), 128'd0);
    check_val("rst_arg", bus.rsp_arg, 128'd0);
    reset = 1'b0;
    tick(2);

    // Known R7-style response, start bit on the 8th edge
    va = mk_short(6'h08, 32'h0000_01AA);
    run_rsp("r7", va, 1'b0, 1'b1, 7);
    check_val("r7_hold_idx", 128'(bus.rsp_index), 128'h08);

    v = va ^ 136'h2;
    run_rsp("crcbad_chk", v, 1'b0, 1'b1, 3);
    check_val("crcbad_flag", 128'(cap_crc), 128'd1);
    run_rsp("crcbad_nochk", v, 1'b0, 1'b0, 3);

    v = {8'h3F, 128'h1D41_4453_4443_4152_4410_0000_1234_5601};
    run_rsp("cid", v, 1'b1, 1'b0, 5);

    v = va;
    v[0] = 1'b0;
    run_rsp("endbit", v, 1'b0, 1'b1, 2);
    check_val("endbit_flag", 128'(cap_end), 128'd1);

    // No start bit for 64 edges; a second arm while busy must not restart the count
    d0 = done_cnt;
    arm(1'b0, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      sd_bit(1'b1, ec);
      if (i == 10) begin
        check_val("to_busy", 128'(bus.rsp_busy), 128'd1);
        arm(1'b1, 1'b0);
      end
    end
    tick(3);
    check_val("to_cnt", 128'(done_cnt - d0), 128'd1);
    check_val("to_lat", 128'(done_cyc), 128'(ec + 1));
    check_val("to_flag", 128'(cap_to), 128'd1);
    check_val("to_hold", 128'(bus.rsp_timeout), 128'd1);

    // Reset part-way through a response
    run_rsp("pre_rst", va, 1'b0, 1'b1, 1);
    d0 = done_cnt;
    arm(1'b0, 1'b1);
    send(va >> 28, 20, ec);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check_val("mrst_busy", 128'(bus.rsp_busy), 128'd0);
    check_val("mrst_arg", bus.rsp_arg, 128'd0);
    check_val("mrst_idx", 128'(bus.rsp_index), 128'd0);
    check_val("mrst_flags", 128'({bus.rsp_crc_err, bus.rsp_end_err, bus.rsp_timeout}), 128'd0);
    send(va, 28, ec);
    tick(4);
    check_val("mrst_nostrb", 128'(done_cnt - d0), 128'd0);

    // Clock loses stability at bit 30
    run_rsp("pre_unst", va, 1'b0, 1'b1, 0);
    v = mk_short(6'h2A, 32'hDEAD_BEEF);
    d0 = done_cnt;
    arm(1'b0, 1'b1);
    send(v >> 18, 30, ec);
    bus.sd_clk_stable = 1'b0;
    dc = cyc;
    tick(3);
    bus.sd_clk_stable = 1'b1;
    check_val("unst_cnt", 128'(done_cnt - d0), 128'd1);
    check_val("unst_lat", 128'(done_cyc), 128'(dc + 1));
    check_val("unst_to", 128'(cap_to), 128'd1);
    check_val("unst_arg", cap_arg, {96'd0, va[39:8]});
    check_val("unst_idx", 128'(cap_idx), 128'(va[45:40]));

    // Arm while the SD clock is not stable
    bus.sd_clk_stable = 1'b0;
    d0 = done_cnt;
    dc = cyc;
    arm(1'b0, 1'b1);
    tick(2);
    bus.sd_clk_stable = 1'b1;
    check_val("noclk_cnt", 128'(done_cnt - d0), 128'd1);
    check_val("noclk_lat", 128'(done_cyc), 128'(dc + 1));
    check_val("noclk_to", 128'(cap_to), 128'd1);

    for (int t = 0; t < 16; t++) begin
      logic lng, chk;
      lng = 1'($urandom % 2);
      chk = 1'($urandom % 2);
      if (lng) v = mk_long({$urandom, $urandom, $urandom, $urandom});
      else     v = mk_short(6'($urandom), $urandom);
      if ($urandom % 4 == 0) v[$urandom_range(1, 7)] ^= 1'b1;
      if ($urandom % 5 == 0) v[0] = 1'b0;
      run_rsp($sformatf("rnd%0d", t), v, lng, chk, int'($urandom_range(0, 40)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
